adder_serial: RTL and testbench
===============================

Name: adder_serial

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor.
- Processes operands CHUNK bits per clock, least-significant chunk first, with a start/ready handshake.
- Successor to the combinational ripple-carry adder: trades latency for a CHUNK-bit carry chain, which shortens the critical path for wide words.
- Adds a subtract mode plus carry and signed-overflow flags. Sits in the arithmetics library, feeding future ALU/multiplier datapaths.

Parameters:
- BITS, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ BITS.
- Derived: NUM_CHUNKS = BITS/CHUNK.

Ports:
- in_clk  in  1  system clock, rising edge.
- in_rst  in  1  asynchronous reset, active-high.
- in_start  in  1  request operation; sampled only when out_busy=0.
- in_sub  in  1  0: a+b; 1: a-b; sampled with in_start.
- in_a  in  BITS  operand a; sampled with in_start.
- in_b  in  BITS  operand b; sampled with in_start.
- out_busy  out  1  high while computing.
- out_ready  out  1  one-cycle pulse when a result is valid.
- out_sum  out  BITS  result, held until the next completion.
- out_carry  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- out_overflow  out  1  signed overflow of the completed operation.

Behaviour:
- Reset (async, in_rst=1):
  - state=IDLE.
  - out_busy=0, out_ready=0, out_sum=0, out_carry=0, out_overflow=0.
  - Internal operand, chunk-index and carry registers cleared.
  - Reset mid-operation aborts it; no out_ready is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - If in_start=1 at an edge:
    - latch a = in_a;
    - latch b' = in_sub ? ~in_b : in_b;
    - carry register = in_sub;
    - chunk index = 0;
    - next state RUN.
  - Otherwise go to (or stay in) IDLE.
  - Back-to-back start in the DONE cycle is accepted.
- RUN:
  - Each edge computes {c, s} = a[idx] + b'[idx] + carry, where [idx] is the CHUNK-bit slice idx.
  - s is written to slice idx of the internal sum register; carry = c; idx increments.
  - On the edge processing idx = NUM_CHUNKS-1:
    - transfer the full sum to out_sum;
    - out_carry = final c;
    - out_overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]);
    - next state DONE.
- Outputs:
  - out_busy = (state == RUN), registered.
  - out_ready = 1 only in DONE, exactly one cycle.
- Latency:
  - start sampled at edge E0; out_ready high after edge E_NUM_CHUNKS.
  - Result is available NUM_CHUNKS cycles after the start edge.
  - CHUNK=BITS gives latency 1.
- in_start while out_busy=1 is ignored; the operation in progress is unaffected.
- Input changes during RUN have no effect; operands are latched.
- out_sum, out_carry and out_overflow:
  - change only on the completion edge or on reset;
  - hold their values through IDLE and through a subsequent RUN until that operation completes.
- Result is the BITS-bit modular sum/difference; wrap-around is not saturated, only flagged.
- Index counter width is clog2(NUM_CHUNKS), minimum 1. Generate-time assertion: BITS % CHUNK == 0.

Test Plan:
- BITS=16, CHUNK=4, a=123, b=234, sub=0, start one cycle:
  - out_busy high for 4 cycles;
  - out_ready pulses on the 4th edge after start;
  - out_sum=357 (0x0165), carry=0, overflow=0.
- a=123, b=234, sub=1:
  - out_sum=0xFF91 (-111), carry=0 (borrow), overflow=0.
- a=0x7FFF, b=1, sub=0:
  - out_sum=0x8000, carry=0, overflow=1.
- a=0xFFFF, b=1, sub=0:
  - out_sum=0x0000, carry=1, overflow=0.
- a=0x8000, b=1, sub=1:
  - out_sum=0x7FFF, carry=1, overflow=1.
- Handshake:
  - Start while busy (a=1, b=1) is ignored; the first result is unchanged.
  - in_rst asserted at cycle 2 of a run drops out_busy and zeroes outputs immediately (asynchronously), with no out_ready.
  - Restart after reset completes normally.
  - Start asserted during the out_ready cycle begins a new run on that edge.
  - Repeat the first scenario with CHUNK=16: out_ready one cycle after start.

Source files
------------

// File: rtl/adder_serial.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with start/busy/ready handshake and carry / signed-overflow flags.
module adder_serial #(
    parameter int BITS  = 16,
    parameter int CHUNK = 4
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_start,
    input  logic            in_sub,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    output logic            out_busy,
    output logic            out_ready,
    output logic [BITS-1:0] out_sum,
    output logic            out_carry,
    output logic            out_overflow
);

    localparam int NUM_CHUNKS = BITS / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (CHUNK < 1 || CHUNK > BITS || (BITS % CHUNK) != 0) begin : g_bad_chunk
        $error("adder_serial: BITS must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [BITS-1:0]  a_q;
    logic [BITS-1:0]  b_q;      // already inverted for subtraction
    logic [BITS-1:0]  sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;

    int               base;
    logic [CHUNK:0]   chunk_res;
    logic [BITS-1:0]  sum_next;
    logic             ovf_next;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        base      = int'(idx) * CHUNK;
        chunk_res = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        sum_next  = sum_q;
        sum_next[base +: CHUNK] = chunk_res[CHUNK-1:0];
        ovf_next  = (a_q[BITS-1] == b_q[BITS-1]) && (sum_next[BITS-1] != a_q[BITS-1]);
    end

    // NOTE: operand and partial-sum registers are plain flops, not a memory, so they are reset too.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            idx          <= '0;
            out_busy     <= 1'b0;
            out_ready    <= 1'b0;
            out_sum      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    out_ready <= 1'b0;
                    if (in_start) begin
                        // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
                        a_q      <= in_a;
                        b_q      <= in_sub ? ~in_b : in_b;
                        carry_q  <= in_sub;
                        idx      <= '0;
                        out_busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= chunk_res[CHUNK];
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_sum      <= sum_next;
                        out_carry    <= chunk_res[CHUNK];
                        out_overflow <= ovf_next;
                        out_ready    <= 1'b1;
                        out_busy     <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial.sv
// Scoreboard bench for adder_serial: a 16/4 instance for the main scenarios
// and a 16/16 instance for the single-cycle latency case.
module tb_adder_serial;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub;
    logic [15:0] a, b;
    logic        busy, ready, carry, ovf;
    logic [15:0] sum;
    logic        start16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, ready16, carry16, ovf16;
    logic [15:0] sum16;

    res_t q[$];
    res_t q16[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    adder_serial #(.BITS(16), .CHUNK(4)) u_dut (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_sub(sub), .in_a(a), .in_b(b),
        .out_busy(busy), .out_ready(ready), .out_sum(sum), .out_carry(carry),
        .out_overflow(ovf)
    );

    adder_serial #(.BITS(16), .CHUNK(16)) u_dut16 (
        .in_clk(clk), .in_rst(rst), .in_start(start16), .in_sub(sub16), .in_a(a16), .in_b(b16),
        .out_busy(busy16), .out_ready(ready16), .out_sum(sum16), .out_carry(carry16),
        .out_overflow(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] f;
        res_t        r;
        yy    = s ? ~y : y;
        f     = {1'b0, x} + {1'b0, yy} + 17'(s);
        r.sum = f[15:0];
        r.c   = f[16];
        r.v   = (x[15] == yy[15]) && (f[15] != x[15]);
        return r;
    endfunction

    always @(negedge clk) begin : mon
        res_t e;
        if (!rst && ready) begin
            if (q.size() == 0) check("spurious_ready", 32'(ready), 32'd0);
            else begin
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("carry", 32'(carry), 32'(e.c));
                check("overflow", 32'(ovf), 32'(e.v));
            end
        end
    end

    always @(negedge clk) begin : mon16
        res_t e;
        if (!rst && ready16) begin
            if (q16.size() == 0) check("spurious_ready16", 32'(ready16), 32'd0);
            else begin
                e = q16.pop_front();
                check("sum16", 32'(sum16), 32'(e.sum));
                check("carry16", 32'(carry16), 32'(e.c));
                check("overflow16", 32'(ovf16), 32'(e.v));
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the start edge.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s, input res_t e);
        a = x; b = y; sub = s; start = 1'b1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_op16(input logic [15:0] x, input logic [15:0] y, input logic s, input res_t e);
        a16 = x; b16 = y; sub16 = s; start16 = 1'b1;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && (q.size() != 0 || q16.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        check("timeout_pending", 32'(q.size() + q16.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] rx, ry;
        logic        rs;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", 32'({carry, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with cycle-accurate handshake timing.
        do_op(16'd123, 16'd234, 1'b0, '{16'h0165, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            check("busy_during_run", 32'(busy), 32'd1);
            check("ready_during_run", 32'(ready), 32'd0);
            @(negedge clk);
        end
        check("busy_at_done", 32'(busy), 32'd0);
        check("ready_at_done", 32'(ready), 32'd1);
        @(negedge clk);
        check("ready_one_cycle", 32'(ready), 32'd0);
        check("sum_held_idle", 32'(sum), 32'h0165);

        do_op(16'd123, 16'd234, 1'b1, '{16'hFF91, 1'b0, 1'b0}); wait_done();
        do_op(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}); wait_done();
        do_op(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}); wait_done();
        do_op(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}); wait_done();
        for (int i = 0; i < 8; i++) begin
            rx = 16'($urandom); ry = 16'($urandom); rs = 1'($urandom);
            do_op(rx, ry, rs, model(rx, ry, rs)); wait_done();
        end

        // Start while busy, with operands changing mid-run: both must be ignored.
        do_op(16'd100, 16'd23, 1'b0, '{16'd123, 1'b0, 1'b0});
        a = 16'd1; b = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);

        // Back-to-back start accepted in the ready cycle; old result holds through the new run.
        do_op(16'h1234, 16'h1111, 1'b0, model(16'h1234, 16'h1111, 1'b0));
        for (int i = 0; i < 10 && !ready; i++) @(negedge clk);
        check("b2b_first_ready", 32'(ready), 32'd1);
        do_op(16'h0F0F, 16'h0101, 1'b1, model(16'h0F0F, 16'h0101, 1'b1));
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_sum_held", 32'(sum), 32'h2345);
        wait_done();

        // Asynchronous reset mid-run aborts the operation.
        do_op(16'h0AAA, 16'h0555, 1'b0, model(16'h0AAA, 16'h0555, 1'b0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_flags", 32'({carry, ovf}), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_ready", 32'(ready), 32'd0);
        do_op(16'h4000, 16'h4000, 1'b0, '{16'h8000, 1'b0, 1'b1}); wait_done();

        // Full-width chunk: single-cycle latency.
        do_op16(16'd123, 16'd234, 1'b0, '{16'h0165, 1'b0, 1'b0});
        check("w16_busy", 32'(busy16), 32'd1);
        check("w16_not_ready", 32'(ready16), 32'd0);
        @(negedge clk);
        check("w16_ready", 32'(ready16), 32'd1);
        check("w16_busy_done", 32'(busy16), 32'd0);
        do_op16(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}); wait_done();
        for (int i = 0; i < 4; i++) begin
            rx = 16'($urandom); ry = 16'($urandom); rs = 1'($urandom);
            do_op16(rx, ry, rs, model(rx, ry, rs)); wait_done();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
